// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit link and its slave receiver.
// Words travel LSB first; the receiver frames words by SPIClk idle time.
package spi_pkg;
  localparam int          SPI_WORD_BITS   = 16;
  localparam logic [15:0] SPI_RX_IDLETIME = 16'h1FF;

  typedef enum logic [2:0] {
    TX_RESYNC = 3'd0,
    TX_IDLE   = 3'd1,
    TX_LOW    = 3'd2,
    TX_HIGH   = 3'd3,
    TX_GAP    = 3'd4
  } tx_state_e;
endpackage

// File: rtl/spi_master_tx_if.sv
// Word handshake between the producer (master) and the SPI transmitter (slave).
interface spi_master_tx_if;
  import spi_pkg::*;

  logic [SPI_WORD_BITS-1:0] data_in;
  logic                     data_valid;
  logic                     ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/spi_phase_timer.sv
// Phase timer: counts clocks since the last clear and flags the final clock
// of a phase whose length is given by limit.
module spi_phase_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tc
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + ONE;
  end

  assign tc = (cnt == limit - ONE);
endmodule

// File: rtl/spi_master_tx.sv
// SPI-style word transmitter: 16-bit words shifted out LSB first on an
// idle-low SPIClk, data launched on the falling edge, sampled by the rise.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD   = 8,
  parameter int GAP_CYCLES    = 8,
  parameter int RESYNC_CYCLES = 1024
) (
  input  logic           clock,
  input  logic           reset,
  spi_master_tx_if.slave host,
  output logic           SPIClk,
  output logic           SPIData,
  output logic           busy,
  output logic           data_sent
);
  localparam int         TW       = 16;
  localparam logic [3:0] LAST_IDX = 4'(SPI_WORD_BITS - 1);

  if (HALF_PERIOD < 4 || HALF_PERIOD > 511 || HALF_PERIOD >= int'(SPI_RX_IDLETIME)) begin : g_bad_half
    $error("spi_master_tx: HALF_PERIOD out of range");
  end
  if (GAP_CYCLES < 4 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("spi_master_tx: GAP_CYCLES out of range");
  end
  if (RESYNC_CYCLES <= 32'h200 || RESYNC_CYCLES > 65535) begin : g_bad_resync
    $error("spi_master_tx: RESYNC_CYCLES out of range");
  end

  tx_state_e                state, state_n;
  logic [TW-1:0]            tmr_lim;
  logic                     tmr_clr, tc, accept, last_bit;
  logic [SPI_WORD_BITS-1:0] hold;
  logic [3:0]               bit_idx;

  assign last_bit    = (bit_idx == LAST_IDX);
  assign host.ready  = (state == TX_IDLE);
  assign accept      = (state == TX_IDLE) && host.data_valid;
  assign busy        = (state == TX_LOW) || (state == TX_HIGH) || (state == TX_GAP);
  assign tmr_lim     = (state == TX_RESYNC) ? TW'(RESYNC_CYCLES) :
                       (state == TX_GAP)    ? TW'(GAP_CYCLES)    : TW'(HALF_PERIOD);
  // Timer restarts at every phase change and sits at zero while idle.
  assign tmr_clr     = (state == TX_IDLE) || (state_n != state);

  spi_phase_timer #(.W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (tmr_clr),
    .limit (tmr_lim),
    .tc    (tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= TX_RESYNC;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      TX_RESYNC: if (tc)     state_n = TX_IDLE;
      TX_IDLE:   if (accept) state_n = TX_LOW;
      TX_LOW:    if (tc)     state_n = TX_HIGH;
      TX_HIGH:   if (tc)     state_n = last_bit ? TX_GAP : TX_LOW;
      TX_GAP:    if (tc)     state_n = TX_IDLE;
      default:               state_n = TX_RESYNC;
    endcase
  end

  // Next bit is launched on the same clock as the fall, so it has a full
  // low phase of setup before the following rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      bit_idx   <= '0;
      SPIClk    <= 1'b0;
      SPIData   <= 1'b0;
      data_sent <= 1'b0;
    end else begin
      data_sent <= (state == TX_GAP) && tc;
      if (accept) begin
        hold    <= host.data_in;
        bit_idx <= '0;
        SPIData <= host.data_in[0];
      end else if (state == TX_LOW && tc) begin
        SPIClk <= 1'b1;
      end else if (state == TX_HIGH && tc) begin
        SPIClk <= 1'b0;
        if (!last_bit) begin
          bit_idx <= bit_idx + 4'd1;
          SPIData <= hold[bit_idx + 4'd1];
        end
      end
    end
  end
endmodule
